// File: rtl/voice_write_master_pkg.sv
// ---------------------------------------------------------------------------
// synth_ctrl_pkg
// Shared types and constants for the synth control-register write master:
//   - state_t        : write-master FSM states
//   - voice_entry_t  : one voice-table entry {active, note[6:0]}
//   - KEY_BASE_ADDR / FREQ_BASE_ADDR : default word addresses of KEY0/FREQ0
//   - reg_addr()     : base + voice index, truncated to the 6-bit bus address
// ---------------------------------------------------------------------------
package synth_ctrl_pkg;

  localparam int KEY_BASE_ADDR  = 32;
  localparam int FREQ_BASE_ADDR = 40;
  localparam int MAX_VOICES     = 8;
  localparam int VIDX_W         = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALLOC   = 2'd1,
    WR_FREQ = 2'd2,
    WR_KEY  = 2'd3
  } state_t;

  typedef struct packed {
    logic       active;
    logic [6:0] note;
  } voice_entry_t;

  function automatic logic [5:0] reg_addr(input int base, input logic [VIDX_W-1:0] idx);
    return 6'(base) + {3'b000, idx};
  endfunction

endpackage

// File: rtl/voice_write_master_if.sv
// ---------------------------------------------------------------------------
// voice_write_master_if
// Bundles the note-event handshake and the Avalon-MM write bus.
//   Event side : EV_VALID, EV_READY, EV_NOTE_ON, EV_NOTE[6:0]
//   Avalon side: AVM_ADDR[5:0], AVM_BYTE_EN[3:0], AVM_WRITE,
//                AVM_WRITEDATA[31:0], AVM_WAITREQUEST
// Modports:
//   master : the write master (accepts events, drives the Avalon bus)
//   slave  : the environment (event source + register-file slave)
//
// Handshake semantics:
//   Event  : an event transfers on a rising edge where EV_VALID & EV_READY.
//            EV_READY does not depend on EV_VALID.
//   Avalon : a write transfers on a rising edge where AVM_WRITE &
//            !AVM_WAITREQUEST; while stalled, AVM_ADDR/AVM_WRITEDATA hold.
// ---------------------------------------------------------------------------
interface voice_write_master_if;

  logic        EV_VALID;
  logic        EV_READY;
  logic        EV_NOTE_ON;
  logic [6:0]  EV_NOTE;

  logic [5:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic        AVM_WRITE;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    input  EV_VALID, EV_NOTE_ON, EV_NOTE, AVM_WAITREQUEST,
    output EV_READY, AVM_ADDR, AVM_BYTE_EN, AVM_WRITE, AVM_WRITEDATA
  );

  modport slave (
    output EV_VALID, EV_NOTE_ON, EV_NOTE, AVM_WAITREQUEST,
    input  EV_READY, AVM_ADDR, AVM_BYTE_EN, AVM_WRITE, AVM_WRITEDATA
  );

endinterface

// File: rtl/voice_write_master_voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Combinational search of the voice table for an event note.
//   voices_i    : voice table (entry n = voice n)
//   note_i      : note number being looked up
//   match_hit_o : some active voice holds note_i
//   match_idx_o : lowest-index active voice holding note_i
//   free_hit_o  : some voice is inactive
//   free_idx_o  : lowest-index inactive voice
// ---------------------------------------------------------------------------
module voice_allocator
  import synth_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  voice_entry_t [NUM_VOICES-1:0] voices_i,
  input  logic [6:0]                    note_i,
  output logic                          match_hit_o,
  output logic [VIDX_W-1:0]             match_idx_o,
  output logic                          free_hit_o,
  output logic [VIDX_W-1:0]             free_idx_o
);

  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    match_hit_o = 1'b0;
    match_idx_o = '0;
    free_hit_o  = 1'b0;
    free_idx_o  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voices_i[i].active && (voices_i[i].note == note_i)) begin
        match_hit_o = 1'b1;
        match_idx_o = VIDX_W'(i);
      end
      if (!voices_i[i].active) begin
        free_hit_o = 1'b1;
        free_idx_o = VIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_write_master.sv
// ---------------------------------------------------------------------------
// voice_write_master
// Avalon-MM master turning note-on/note-off events into FREQ/KEY register
// writes on the synth control register file. Keeps a per-voice table of the
// held note, allocates a voice on note-on (retrigger, else lowest free),
// clears the KEY of the matching voice on note-off.
//
// Ports:
//   CLK, RESET    : clock, synchronous active-high reset
//   bus           : voice_write_master_if.master (event handshake + Avalon)
//   VOICE_ACTIVE  : bit n = voice n holds a note (registered)
//   DROP          : one-cycle pulse when a note-on is discarded
//   dbg_state_o   : current FSM state
//
// Build option VOICE_STEAL_EN: when defined, a note-on with every voice busy
// takes the voice at a round-robin steal pointer instead of being dropped.
// ---------------------------------------------------------------------------
module voice_write_master
  import synth_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int KEY_BASE   = KEY_BASE_ADDR,
  parameter int FREQ_BASE  = FREQ_BASE_ADDR
) (
  input  logic                    CLK,
  input  logic                    RESET,
  voice_write_master_if.master    bus,
  output logic [NUM_VOICES-1:0]   VOICE_ACTIVE,
  output logic                    DROP,
  output state_t                  dbg_state_o
);

  state_t                        state_q;
  logic                          ev_on_q;
  logic [6:0]                    ev_note_q;
  logic [VIDX_W-1:0]             tgt_q;
  voice_entry_t [NUM_VOICES-1:0] voices_q;
  logic [5:0]                    addr_q;
  logic [31:0]                   wdata_q;
  logic                          write_q;
  logic                          drop_q;
`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0]             steal_ptr_q;
  logic                          steal_q;
  logic                          alloc_steal_d;
`endif

  logic              match_hit;
  logic [VIDX_W-1:0] match_idx;
  logic              free_hit;
  logic [VIDX_W-1:0] free_idx;

  // Decision taken in ALLOC
  state_t            alloc_state_d;
  logic [VIDX_W-1:0] alloc_tgt_d;
  logic              alloc_drop_d;

  voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .voices_i    (voices_q),
    .note_i      (ev_note_q),
    .match_hit_o (match_hit),
    .match_idx_o (match_idx),
    .free_hit_o  (free_hit),
    .free_idx_o  (free_idx)
  );

  always_comb begin
    alloc_state_d = IDLE;
    alloc_tgt_d   = '0;
    alloc_drop_d  = 1'b0;
`ifdef VOICE_STEAL_EN
    alloc_steal_d = 1'b0;
`endif
    if (ev_on_q) begin
      if (match_hit) begin
        // Retrigger the voice already holding this note.
        alloc_state_d = WR_FREQ;
        alloc_tgt_d   = match_idx;
      end else if (free_hit) begin
        alloc_state_d = WR_FREQ;
        alloc_tgt_d   = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        alloc_state_d = WR_FREQ;
        alloc_tgt_d   = steal_ptr_q;
        alloc_steal_d = 1'b1;
`else
        alloc_drop_d  = 1'b1;
`endif
      end
    end else if (match_hit) begin
      alloc_state_d = WR_KEY;
      alloc_tgt_d   = match_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      tgt_q       <= '0;
      voices_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      drop_q      <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
      steal_q     <= 1'b0;
`endif
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.EV_VALID) begin
            ev_on_q   <= bus.EV_NOTE_ON;
            ev_note_q <= bus.EV_NOTE;
            state_q   <= ALLOC;
          end
        end
        ALLOC: begin
          state_q <= alloc_state_d;
          tgt_q   <= alloc_tgt_d;
          drop_q  <= alloc_drop_d;
`ifdef VOICE_STEAL_EN
          steal_q <= alloc_steal_d;
`endif
          if (alloc_state_d == WR_FREQ) begin
            write_q <= 1'b1;
            addr_q  <= reg_addr(FREQ_BASE, alloc_tgt_d);
            wdata_q <= {25'b0, ev_note_q};
          end else if (alloc_state_d == WR_KEY) begin
            write_q <= 1'b1;
            addr_q  <= reg_addr(KEY_BASE, alloc_tgt_d);
            wdata_q <= {31'b0, ev_on_q};
          end
        end
        WR_FREQ: begin
          if (!bus.AVM_WAITREQUEST) begin
            state_q <= WR_KEY;
            addr_q  <= reg_addr(KEY_BASE, tgt_q);
            wdata_q <= {31'b0, ev_on_q};
          end
        end
        WR_KEY: begin
          if (!bus.AVM_WAITREQUEST) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            // The table only changes once the KEY write has landed, so it
            // always mirrors what the register file holds.
            voices_q[tgt_q].active <= ev_on_q;
            if (ev_on_q) begin
              voices_q[tgt_q].note <= ev_note_q;
            end
`ifdef VOICE_STEAL_EN
            if (steal_q) begin
              steal_ptr_q <= (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) ? '0
                                                                      : steal_ptr_q + 1'b1;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    VOICE_ACTIVE = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      VOICE_ACTIVE[i] = voices_q[i].active;
    end
  end

  assign bus.EV_READY      = (state_q == IDLE);
  assign bus.AVM_ADDR      = addr_q;
  assign bus.AVM_BYTE_EN   = 4'hF;
  assign bus.AVM_WRITE     = write_q;
  assign bus.AVM_WRITEDATA = wdata_q;
  assign DROP              = drop_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_voice_write_master.sv
// ---------------------------------------------------------------------------
// tb_voice_write_master
// Directed stimulus for voice_write_master. Expected bus writes (cycle,
// address, data) are queued when an event is issued; a monitor pops and
// compares each completed Avalon write and checks address/data hold during
// wait states. Cycle numbers are counted from the event acceptance cycle.
// ---------------------------------------------------------------------------
module tb_voice_write_master;
  import synth_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  voice_write_master_if bus();
  logic [7:0] voice_active;
  logic       drop;
  state_t     dbg_state;

  voice_write_master #(.NUM_VOICES(8), .KEY_BASE(32), .FREQ_BASE(40)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .bus          (bus),
    .VOICE_ACTIVE (voice_active),
    .DROP         (drop),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int errors   = 0;
  int drop_cnt = 0;
  logic [53:0] exp_q[$];   // {cycle[15:0], addr[5:0], data[31:0]}

  int         stall_left = 0;
  logic [5:0] stall_addr = '0;

  function automatic logic [53:0] mk(input int c, input int a, input int d);
    return {16'(c), 6'(a), 32'(d)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- wait-state driver ----------------
  initial begin
    bus.AVM_WAITREQUEST = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.AVM_WRITE && bus.AVM_ADDR == stall_addr) begin
        bus.AVM_WAITREQUEST = 1'b1;
        stall_left--;
      end else begin
        bus.AVM_WAITREQUEST = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        prev_stall;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic [53:0] e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_write", bus.AVM_WRITE, 1);
          check("hold_addr", bus.AVM_ADDR, prev_addr);
          check("hold_data", bus.AVM_WRITEDATA, prev_data);
        end
        if (bus.AVM_WRITE && !bus.AVM_WAITREQUEST) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h at cycle %0d, none expected",
                     bus.AVM_ADDR, bus.AVM_WRITEDATA, cyc);
          end else begin
            e = exp_q.pop_front();
            check("wr_cycle", 16'(cyc), e[53:38]);
            check("wr_addr", bus.AVM_ADDR, e[37:32]);
            check("wr_data", bus.AVM_WRITEDATA, e[31:0]);
          end
        end
        if (drop) drop_cnt++;
        prev_stall = bus.AVM_WRITE && bus.AVM_WAITREQUEST;
        prev_addr  = bus.AVM_ADDR;
        prev_data  = bus.AVM_WRITEDATA;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents an event; returns the cycle in which it was accepted.
  task automatic send_event(input logic on, input logic [6:0] note, output int acc);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.EV_VALID   = 1'b1;
    bus.EV_NOTE_ON = on;
    bus.EV_NOTE    = note;
    @(negedge clk);
    while (!bus.EV_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.EV_READY) begin
      checks++;
      errors++;
      $display("FAIL ev_accept_timeout: EV_READY=0 for %0d cycles, required 1", n);
    end
    acc = cyc;
    @(posedge clk);
    #1;
    bus.EV_VALID = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after acc with EV_READY high.
  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    rc = -1;
    while (n < 60) begin
      @(negedge clk);
      if (bus.EV_READY) begin
        rc = cyc;
        break;
      end
      n++;
    end
    if (rc < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: EV_READY=0 for %0d cycles, required 1", n);
    end
  endtask

  // One event with its expected writes; extra = wait-state cycles inserted.
  task automatic run_event(input logic on, input logic [6:0] note, input int nwr,
                           input int a0, input int d0, input int a1, input int d1,
                           input int extra, input string name);
    int acc;
    int rc;
    send_event(on, note, acc);
    if (nwr >= 1) exp_q.push_back(mk(acc + 2 + extra, a0, d0));
    if (nwr >= 2) exp_q.push_back(mk(acc + 3 + extra, a1, d1));
    wait_ready(rc);
    check({name, "_ready_cycle"}, 64'(rc - acc), 64'(2 + nwr + extra));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    bus.EV_VALID   = 1'b0;
    bus.EV_NOTE_ON = 1'b0;
    bus.EV_NOTE    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ev_ready", bus.EV_READY, 1);
    check("rst_avm_write", bus.AVM_WRITE, 0);
    check("rst_avm_addr", bus.AVM_ADDR, 0);
    check("rst_avm_wdata", bus.AVM_WRITEDATA, 0);
    check("rst_byte_en", bus.AVM_BYTE_EN, 4'hF);
    check("rst_voice_active", voice_active, 0);
    check("rst_drop", drop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single note-on, zero wait states.
    run_event(1'b1, 7'd60, 2, 40, 60, 32, 1, 0, "on60");
    check("on60_voice_active", voice_active, 8'h01);

    // Two more note-ons, then release the middle one.
    run_event(1'b1, 7'd62, 2, 41, 62, 33, 1, 0, "on62");
    run_event(1'b1, 7'd64, 2, 42, 64, 34, 1, 0, "on64");
    check("three_on_voice_active", voice_active, 8'h07);
    run_event(1'b0, 7'd62, 1, 33, 0, 0, 0, 0, "off62");
    check("off62_voice_active", voice_active, 8'h05);

    // Three wait states on the FREQ write; voice 1 is the lowest free one.
    stall_addr = 6'd41;
    stall_left = 3;
    run_event(1'b1, 7'd70, 2, 41, 70, 33, 1, 3, "stall70");
    check("stall70_voice_active", voice_active, 8'h07);

    // Unmatched note-off: no bus activity.
    run_event(1'b0, 7'd99, 0, 0, 0, 0, 0, 0, "off99");
    check("off99_voice_active", voice_active, 8'h07);

    // Retrigger of a held note reuses voice 0.
    run_event(1'b1, 7'd60, 2, 40, 60, 32, 1, 0, "retrig60");
    check("retrig60_voice_active", voice_active, 8'h07);

    // Fill all voices from a clean table.
    reset_dut();
    @(negedge clk);
    check("reset2_voice_active", voice_active, 0);
    for (int i = 0; i < 8; i++) begin
      run_event(1'b1, 7'(i), 2, 40 + i, i, 32 + i, 1, 0, "fill");
    end
    check("fill_voice_active", voice_active, 8'hFF);

`ifdef VOICE_STEAL_EN
    run_event(1'b1, 7'd8, 2, 40, 8, 32, 1, 0, "steal8");
    run_event(1'b1, 7'd9, 2, 41, 9, 33, 1, 0, "steal9");
    check("steal_voice_active", voice_active, 8'hFF);
`else
    run_event(1'b1, 7'd8, 0, 0, 0, 0, 0, 0, "drop8");
    check("drop8_pulse", drop, 1);
    @(negedge clk);
    check("drop8_pulse_end", drop, 0);
    run_event(1'b1, 7'd9, 0, 0, 0, 0, 0, 0, "drop9");
    check("drop9_pulse", drop, 1);
    check("drop_voice_active", voice_active, 8'hFF);
`endif

    // Reset during a stalled KEY write (note-off of voice 5).
    stall_addr = 6'd37;
    stall_left = 1000;
    send_event(1'b0, 7'd5, acc);
    exp_q.push_back(mk(acc + 2, 37, 0));
    @(negedge clk);
    @(negedge clk);
    check("stalled_key_write", bus.AVM_WRITE, 1);
    check("stalled_key_addr", bus.AVM_ADDR, 37);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_avm_write", bus.AVM_WRITE, 0);
    check("midrst_voice_active", voice_active, 0);
    check("midrst_ev_ready", bus.EV_READY, 1);
    check("midrst_avm_addr", bus.AVM_ADDR, 0);
    check("midrst_pending", 64'(exp_q.size()), 1);
    exp_q.delete();
    stall_left = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef VOICE_STEAL_EN
    check("drop_count", 64'(drop_cnt), 0);
`else
    check("drop_count", 64'(drop_cnt), 2);
`endif
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
